// File: rtl/radd_pipe.sv
// Pipelined ripple-carry adder/subtractor: the operand is cut into SEG_W-bit
// carry segments, each resolved in its own register stage.
module radd_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // WIDTH must be a multiple of SEG_W.
   localparam int STAGES = WIDTH / SEG_W;

   // Handshake: a beat moves on a rising edge when valid and ready are both
   // high; ready never depends on valid. The whole pipe advances together
   // whenever the output slot is empty or being drained, so in_ready = adv.
   logic             adv;
   logic [WIDTH-1:0] bx;
   logic             c0;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign bx       = sub ? ~b : b;
   assign c0       = sub ? 1'b1 : cin;

   function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                              input logic [SEG_W-1:0] y,
                                              input logic             ci);
      logic [SEG_W:0] r;
      logic           c;
      r = '0;
      c = ci;
      for (int i = 0; i < SEG_W; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      r[SEG_W] = c;
      return r;
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : stg
      // Operands shrink by one segment per stage; finished sums grow by one.
      localparam int OPW = WIDTH - k * SEG_W;
      localparam int SW  = (k + 1) * SEG_W;

      logic [OPW-1:0] a_d;
      logic [OPW-1:0] b_d;
      logic           c_d;
      logic           v_d;
      logic [SEG_W:0] seg;
      logic [SW-1:0]  s_nx;
      logic           v_q;
      logic           c_q;
      logic [SW-1:0]  s_q;

      assign seg = seg_add(a_d[SEG_W-1:0], b_d[SEG_W-1:0], c_d);

      if (k == 0) begin : head
         assign a_d  = a;
         assign b_d  = bx;
         assign c_d  = c0;
         assign v_d  = in_valid;
         assign s_nx = seg[SEG_W-1:0];
      end else begin : tail
         assign a_d  = stg[k-1].fwd.a_q;
         assign b_d  = stg[k-1].fwd.b_q;
         assign c_d  = stg[k-1].c_q;
         assign v_d  = stg[k-1].v_q;
         assign s_nx = {seg[SEG_W-1:0], stg[k-1].s_q};
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_d;
            c_q <= seg[SEG_W];
            s_q <= s_nx;
         end
      end

      if (k < STAGES - 1) begin : fwd
         logic [OPW-SEG_W-1:0] a_q;
         logic [OPW-SEG_W-1:0] b_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_d[OPW-1:SEG_W];
               b_q <= b_d[OPW-1:SEG_W];
            end
         end
      end

      if (k == STAGES - 1) begin : lst
         logic o_q;

         // Same-sign operands producing a differently signed result.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               o_q <= 1'b0;
            end else if (adv) begin
               o_q <= (a_d[SEG_W-1] == b_d[SEG_W-1]) && (seg[SEG_W-1] != a_d[SEG_W-1]);
            end
         end
      end
   end

   assign out_valid = stg[STAGES-1].v_q;
   assign sum       = stg[STAGES-1].s_q;
   assign cout      = stg[STAGES-1].c_q;
   assign ovf       = stg[STAGES-1].lst.o_q;

endmodule

// File: tb/tb_radd_pipe.sv
// Bench for radd_pipe: directed 32/8 scenarios plus random sweeps over
// (8,8), (8,1) and (16,4) against an a + b' + c0 reference.
module tb_radd_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, sw_rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, sum;

   int          checks = 0;
   int          errors = 0;
   logic [65:0] exp_q[$];
   int          acc_q[$];
   int          stl_q[$];
   int          cyc = 0;
   int          stl = 0;
   logic [11:0] vec;
   logic [34:0] held;
   logic        took_m;

   radd_pipe #(.WIDTH(32), .SEG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] mk(input logic o, input logic c, input logic [63:0] s);
      return {o, c, s};
   endfunction

   // Reference: (WIDTH+1)-bit sum of a + b' + c0, returned as {ovf, cout, sum}.
   function automatic logic [65:0] golden(input int w, input logic [63:0] ga,
                                          input logic [63:0] gb, input logic gc,
                                          input logic gs);
      logic [63:0] mask, bxv, av;
      logic [64:0] full;
      logic        c0v, o;
      mask = (64'd1 << w) - 64'd1;
      av   = ga & mask;
      bxv  = (gs ? ~gb : gb) & mask;
      c0v  = gs ? 1'b1 : gc;
      full = {1'b0, av} + {1'b0, bxv} + {64'd0, c0v};
      o    = (av[w-1] == bxv[w-1]) && (full[w-1] != av[w-1]);
      return {o, full[w], full[63:0] & mask};
   endfunction

   // Main scoreboard: push on accept, pop on drain, latency net of stalls.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         stl_q.delete();
         cyc = 0;
         stl = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("m_spurious", 66'd1, 66'd0);
            end else begin
               check("m_result", mk(ovf, cout, 64'(sum)), exp_q.pop_front());
               check("m_latency", 66'(cyc - acc_q.pop_front() - (stl - stl_q.pop_front())), 66'd4);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(golden(32, 64'(a), 64'(b), cin, sub));
            acc_q.push_back(cyc);
            stl_q.push_back(stl);
         end
         if (out_valid && !out_ready) stl++;
         cyc++;
      end
   end

   task automatic send1(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                        input logic ts, input logic [65:0] want, input string tag);
      @(posedge clk); #1;
      a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_rdy"}, 66'(in_ready), 66'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check($sformatf("%s_vld%0d", tag, j), 66'(out_valid), 66'(j == 3));
         if (j == 3) check({tag, "_val"}, mk(ovf, cout, 64'(sum)), want);
      end
   endtask

   task automatic stream8();
      vec = '0;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               a = 32'(i); b = 32'(i) * 32'h0101_0101; cin = 1'b0; sub = 1'b0;
               in_valid = 1'b1;
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            for (int j = 0; j < 12; j++) begin
               @(negedge clk);
               vec[j] = out_valid;
            end
         end
      join
      check("stream_vld", 66'(vec), 66'h7F8);
   endtask

   task automatic backpressure();
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               a = $urandom(); b = $urandom();
               cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
               in_valid = 1'b1;
               took_m = 1'b0;
               for (int t = 0; t < 40 && !took_m; t++) begin
                  @(negedge clk);
                  took_m = in_ready;
                  @(posedge clk); #1;
               end
               if (!took_m) check("bp_stuck", 66'd0, 66'd1);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (k == 0) begin
                  held = {out_valid, ovf, cout, sum};
                  check("bp_full", 66'(out_valid), 66'd1);
               end else begin
                  check($sformatf("bp_hold%0d", k), 66'({out_valid, ovf, cout, sum}), 66'(held));
               end
               check($sformatf("bp_inrdy%0d", k), 66'(in_ready), 66'd0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
   endtask

   task automatic reset_midflight();
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h1000_0000 + 32'(i); b = 32'h0000_0777; cin = 1'b1; sub = 1'b0;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_vld", 66'(out_valid), 66'd0);
      check("rst_sum", 66'(sum), 66'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      check("rst_q", 66'(exp_q.size()), 66'd0);
   endtask

   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int W = (g == 2) ? 16 : 8;
      localparam int S = (g == 0) ? 8 : ((g == 1) ? 1 : 4);

      logic         iv, ir, ov, orr, ci, sb, co, of, took, done;
      logic [W-1:0] av, bv, sm;
      logic [65:0]  q[$];
      int           aq[$];
      int           sq[$];
      int           scyc = 0;
      int           sstl = 0;
      int           pushed = 0;

      radd_pipe #(.WIDTH(W), .SEG_W(S)) dut (
         .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
         .a(av), .b(bv), .cin(ci), .sub(sb), .out_valid(ov),
         .out_ready(orr), .sum(sm), .cout(co), .ovf(of)
      );

      function automatic logic [W-1:0] pick();
         case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom());
         endcase
      endfunction

      always @(negedge clk) begin
         took = 1'b0;
         if (!sw_rst_n) begin
            q.delete();
            aq.delete();
            sq.delete();
            scyc   = 0;
            sstl   = 0;
            pushed = 0;
         end else begin
            if (ov && orr) begin
               if (q.size() == 0) begin
                  check($sformatf("sw%0d_spurious", g), 66'd1, 66'd0);
               end else begin
                  check($sformatf("sw%0d_result", g), mk(of, co, 64'(sm)), q.pop_front());
                  check($sformatf("sw%0d_latency", g),
                        66'(scyc - aq.pop_front() - (sstl - sq.pop_front())), 66'(W / S));
               end
            end
            if (iv && ir) begin
               q.push_back(golden(W, 64'(av), 64'(bv), ci, sb));
               aq.push_back(scyc);
               sq.push_back(sstl);
               pushed++;
               took = 1'b1;
            end
            if (ov && !orr) sstl++;
            scyc++;
         end
      end

      // Operands are re-randomised whenever no beat is pending, so values
      // that are never accepted keep changing under the DUT.
      initial begin
         done = 1'b0; iv = 1'b0; orr = 1'b0; av = '0; bv = '0; ci = 1'b0; sb = 1'b0;
         wait (sw_rst_n === 1'b1);
         for (int t = 0; t < 30000 && pushed < 2000; t++) begin
            @(posedge clk); #1;
            orr = ($urandom_range(0, 3) != 0);
            if (!iv || took) begin
               iv = ($urandom_range(0, 3) != 0);
               av = pick();
               bv = pick();
               ci = 1'($urandom_range(0, 1));
               sb = 1'($urandom_range(0, 1));
            end
         end
         iv  = 1'b0;
         orr = 1'b1;
         for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
         check($sformatf("sw%0d_beats", g), 66'(pushed), 66'd2000);
         check($sformatf("sw%0d_drain", g), 66'(q.size()), 66'd0);
         done = 1'b1;
      end
   end

   initial begin
      rst_n = 1'b0; sw_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 66'(out_valid), 66'd0);
      check("rst_out_sum", 66'(sum), 66'd0);
      check("rst_out_cout", 66'(cout), 66'd0);
      check("rst_out_ovf", 66'(ovf), 66'd0);
      check("rst_in_ready", 66'(in_ready), 66'd1);
      rst_n = 1'b1; sw_rst_n = 1'b1; out_ready = 1'b1;

      send1(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(1'b0, 1'b0, 64'h0000_0100), "add_ff");
      send1(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(1'b0, 1'b1, 64'h0), "add_ripple");
      send1(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(1'b1, 1'b1, 64'h7FFF_FFFF), "sub_ovf");
      send1(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, mk(1'b0, 1'b0, 64'hFFFF_FFFE), "sub_neg");
      send1(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(1'b1, 1'b0, 64'h8000_0000), "add_ovf");
      stream8();
      repeat (4) @(posedge clk);
      backpressure();
      reset_midflight();

      for (int t = 0; t < 60000 && !(sw[0].done && sw[1].done && sw[2].done); t++) @(posedge clk);
      check("sweep_done", 66'({sw[0].done, sw[1].done, sw[2].done}), 66'h7);
      check("main_drain", 66'(exp_q.size()), 66'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/radd_pipe.md
Name: radd_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; the successor to the fixed 8-bit full-adder chain.
- Operand width is split into SEG_W-bit carry segments, one register stage per segment, so the carry ripple per clock is bounded to SEG_W bits.
- Streams one operation per cycle under a valid/ready handshake with backpressure.
- Sits between operand producers (register file, DSP-less datapaths) and result consumers in mapped benchmarks.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W.
- SEG_W, 8, bits per carry segment; STAGES = WIDTH/SEG_W (1..WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- a  in  WIDTH  operand A (unsigned/two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits cleared; sum, cout, ovf, out_valid = 0; in_ready = 1 in the cycle after reset. Reset mid-operation discards all in-flight beats, with no partial output.
- Global-stall pipeline: adv = !out_valid | out_ready; in_ready = adv (combinational). When adv=0, all stages hold, including data and valid bits.
- Accept: beat accepted when in_valid & in_ready. Stage 0 latches a, (sub ? ~b : b), and initial carry (sub ? 1 : cin). It computes segment 0 sum plus carry_out using a full-adder ripple over SEG_W bits.
- Stage k (1..STAGES-1): adds segment k of the delayed operands with the registered carry from stage k-1. Already-computed lower segment sums are carried forward (skewed delay).
- Latency: result of a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. exactly STAGES register stages, absent stalls. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle when out_ready held high.
- Bubbles: a cycle with in_valid=0 while adv=1 inserts an invalid slot. Invalid stages still advance, and their data is don't-care, but out_valid must be 0 for them.
- Output hold: while out_valid=1 & out_ready=0, sum/cout/ovf/out_valid are stable.
- Arithmetic: sum = (a + b' + c0) mod 2^WIDTH, where b' = sub ? ~b : b and c0 = sub ? 1 : cin. cout = bit WIDTH of the full (WIDTH+1)-bit sum. ovf = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]).
- Simultaneous accept and drain in the same cycle is legal (adv=1 via out_ready=1).
- STAGES=1: single registered stage, latency 1.
- Inputs sampled only on accept; changes on a/b/cin/sub while in_ready=0 have no effect.

Test Plan:
- Reset + single add (WIDTH=32, SEG_W=8): a=0x0000_00FF, b=0x0000_0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0000_0100, cout=0, ovf=0, out_valid one cycle. Full-width carry ripple across segments: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Subtract/overflow: sub=1, a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1. Then a=3, b=5 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Streaming: 8 back-to-back beats a=i, b=i*0x0101_0101, out_ready=1 -> 8 consecutive out_valid cycles starting at latency 4, results in order, no gaps.
- Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 in those cycles, output held stable, no beat lost or duplicated, order preserved.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> next cycle out_valid=0, sum=0; no stale result ever appears after reset release.
- Parameter sweep: (WIDTH,SEG_W) = (8,8), (8,1), (16,4), 2000 random beats with random in_valid/out_ready -> all results match the golden a+b'+c0 model, with latency = WIDTH/SEG_W when unstalled.
